// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: launch FSM state
// encoding and the WAIT_HI timeout length.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_e;

    // Cycles spent in WAIT_HI without seeing tx_busy before giving up
    localparam int WAIT_HI_TIMEOUT = 4;
    localparam int TO_W = $clog2(WAIT_HI_TIMEOUT);

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO in front of the UART launcher: storage, wrapping pointers,
// registered occupancy/full/empty and a sticky overflow flag.
// Ports: push/push_data write side, pop/pop_data read side (pop_data is
// the head entry, valid whenever empty=0), full/empty/count status,
// overflow (sticky) with clr_overflow.
module tx_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance uses the registered flags, so a push while full is
    // dropped even if a pop frees a slot on the same edge.
    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A dropped write wins over a same-cycle clear
        if (push & full_q) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes from game logic and launches them one at a time into an
// 8N1 transmitter via its start/busy handshake.
// Ports: wr_en/wr_data write side; full/empty/count/overflow status with
// clr_overflow; tx_start/tx_data launch outputs; tx_busy from transmitter.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_HI_TIMEOUT - 1);

    tx_state_e       state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            pop;
    logic [7:0]      head_data;

    tx_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (wr_en),
        .push_data    (wr_data),
        .pop          (pop),
        .pop_data     (head_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Pop only from IDLE with a byte waiting and the line free; any
    // busy source, including a foreign one, holds the queue.
    assign pop = (state_q == IDLE) & ~empty & ~tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // No busy after the timeout: the byte is abandoned
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        to_cnt_d  = '0;
        tx_data_d = tx_data_q;
        if (state_q == WAIT_HI) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (pop) begin
            tx_data_d = head_data;
        end
    end

    // Decoded from the state register only, so reset clears it at once
    assign tx_start = (state_q == START);
    assign tx_data  = tx_data_q;

endmodule
